// File: rtl/xbar_return_arbiter.sv
// Return-path arbiter for one crossbar master: round-robin selection among slave
// return FIFOs whose head targets this master, with optional burst lock until RLAST.
module xbar_return_arbiter #(
  parameter int masters            = 2,
  parameter int slaves             = 2,
  parameter int i_am_master_number = 0,
  parameter int LOCK_ON_LAST       = 1,
  localparam int MW = $clog2(masters),
  localparam int SW = $clog2(slaves)
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          slave_fifo_empty  [0:slaves-1],
  input  logic [MW-1:0] slave_dest_master [0:slaves-1],
  input  logic          slave_front_last  [0:slaves-1],
  input  logic          master_fifo_full,
  output logic [SW-1:0] grant_slave_number,
  output logic          grant_valid,
  output logic          push_to_fifo,
  output logic          locked
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          r_state, w_state_next;
  logic [SW-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [SW-1:0]   r_lock_slave, w_lock_slave_next;
  logic [slaves-1:0] w_req;
  logic [SW-1:0]   w_cand [slaves];
  logic [SW-1:0]   w_rr_pick;
  logic [SW-1:0]   w_grant;
  logic            w_grant_valid;
  logic            w_xfer;
  logic            w_last;

  genvar gi;
  generate
    for (gi = 0; gi < slaves; gi++) begin : g_slave
      logic [SW:0] w_sum;
      assign w_req[gi] = ~slave_fifo_empty[gi] &
                         (slave_dest_master[gi] == MW'(i_am_master_number));
      // Candidate gi is offset gi+1 past rr_ptr; the extra bit keeps the wrap exact
      // for non-power-of-2 slave counts.
      assign w_sum       = {1'b0, r_rr_ptr} + (SW+1)'(gi + 1);
      assign w_cand[gi]  = (w_sum >= (SW+1)'(slaves)) ? SW'(w_sum - (SW+1)'(slaves))
                                                      : SW'(w_sum);
    end
  endgenerate

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    w_rr_pick = r_rr_ptr;
    for (int k = slaves - 1; k >= 0; k--) begin
      if (w_req[w_cand[k]]) w_rr_pick = w_cand[k];
    end
  end

  always_comb begin
    w_grant           = w_rr_pick;
    w_grant_valid     = |w_req;
    w_state_next      = r_state;
    w_rr_ptr_next     = r_rr_ptr;
    w_lock_slave_next = r_lock_slave;
    if (r_state == ST_LOCKED) begin
      w_grant       = r_lock_slave;
      w_grant_valid = w_req[r_lock_slave];
    end
    w_xfer = w_grant_valid & ~master_fifo_full;
    w_last = slave_front_last[w_grant];
    if (w_xfer) begin
      if (r_state == ST_LOCKED) begin
        if (w_last) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = r_lock_slave;
        end
      end else if ((LOCK_ON_LAST != 0) && !w_last) begin
        // First beat of a multi-beat burst: hold this slave, defer the pointer.
        w_state_next      = ST_LOCKED;
        w_lock_slave_next = w_grant;
      end else begin
        w_rr_ptr_next = w_grant;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= SW'(slaves - 1);
      r_lock_slave <= '0;
    end else begin
      r_state      <= w_state_next;
      r_rr_ptr     <= w_rr_ptr_next;
      r_lock_slave <= w_lock_slave_next;
    end
  end

  assign grant_slave_number = ARESETn ? w_grant : '0;
  assign grant_valid        = ARESETn & w_grant_valid;
  assign push_to_fifo       = ARESETn & w_xfer;
  assign locked             = ARESETn & (r_state == ST_LOCKED);

endmodule

// File: doc/xbar_return_arbiter.md
# xbar_return_arbiter

Per-master return-path arbiter for the crossbar. Each master port instantiates one copy for its read-data path and one for its write-response path. It picks which slave-side return FIFO (R or B) may move its head entry into this master's return FIFO. Arbitration is round-robin among slaves whose head entry is addressed to this master. On the R path the grant is held for the whole burst, so beats of different bursts never interleave.

## Interface
Parameters:
- masters, 2, number of master ports (>=2)
- slaves, 2, number of slave ports (>=2)
- i_am_master_number, 0, index of the master port this instance serves
- LOCK_ON_LAST, 1, 1 = hold grant until a popped entry has last=1 (R path); 0 = re-arbitrate every entry (B path)

Ports:
- ACLK  input  1  clock
- ARESETn  input  1  reset, synchronous, active-low
- slave_fifo_empty  input  1 x [0:slaves-1]  empty flag of each slave return FIFO
- slave_dest_master  input  $clog2(masters) x [0:slaves-1]  decoded destination master of each FIFO head
- slave_front_last  input  1 x [0:slaves-1]  RLAST of each FIFO head; ignored when LOCK_ON_LAST=0
- master_fifo_full  input  1  this master's return FIFO full
- grant_slave_number  output  $clog2(slaves)  selected slave
- grant_valid  output  1  selection is live; slave s pops iff grant_valid & ~master_fifo_full & grant_slave_number==s
- push_to_fifo  output  1  grant_valid & ~master_fifo_full; master return FIFO push
- locked  output  1  state is LOCKED

## Operation
- Request: req[s] = ~slave_fifo_empty[s] & (slave_dest_master[s] == i_am_master_number).
- Transfer (xfer) = push_to_fifo. It is a single-cycle event and moves one entry.
- Registers:
  - state ∈ {IDLE, LOCKED}
  - rr_ptr, $clog2(slaves) bits: last slave that completed a grant
  - lock_slave, $clog2(slaves) bits
- IDLE:
  - grant_slave_number = first s with req[s], searching (rr_ptr+1) mod slaves upward with wrap.
  - grant_valid = |req. If there is no request, grant_slave_number = rr_ptr (held, don't-care) and grant_valid = 0.
  - On xfer, if LOCK_ON_LAST=1 and slave_front_last[grant]=0: state→LOCKED, lock_slave←grant. rr_ptr is not updated.
  - On xfer otherwise: rr_ptr←grant, state stays IDLE.
- LOCKED:
  - grant_slave_number = lock_slave.
  - grant_valid = req[lock_slave]. Other requests are ignored, even if the locked FIFO is empty mid-burst.
  - On xfer with slave_front_last[lock_slave]=1: state→IDLE, rr_ptr←lock_slave.
  - On xfer with last=0: stay LOCKED.
- Fairness: a requesting slave is served within slaves-1 completed grants (bursts on R, entries on B).
- Modulo wrap: the search index is computed in $clog2(slaves)+1 bits and reduced mod slaves. Non-power-of-2 slaves must never select an index >= slaves.
- LOCK_ON_LAST=0: state is constant IDLE and locked=0.

## Timing
- Grant is combinational from the current inputs and registered state. The pop and push that it qualifies occur in the same cycle; there are no bubbles between back-to-back entries.
- Registered state updates at the ACLK edge following xfer.
- Reset (synchronous, ARESETn=0 at an edge):
  - state=IDLE, rr_ptr=slaves-1 (slave 0 highest priority), lock_slave=0.
  - While ARESETn=0: grant_valid=0, push_to_fifo=0, grant_slave_number=0, locked=0.
  - Reset mid-burst abandons the lock immediately. The FIFOs are reset by the same signal.
- master_fifo_full=1: no xfer; state and rr_ptr hold; grant_slave_number stays stable while full.
- A request that appears or disappears in IDLE without xfer changes no state.
- A single-beat burst (last=1 on the first beat) never enters LOCKED.

## Test plan
- Round-robin, LOCK_ON_LAST=0, slaves=2, both slaves holding 3 B entries for master 0, full=0 → grant order 0,1,0,1,0,1; one push per cycle; rr_ptr=1 at the end.
- Burst lock, LOCK_ON_LAST=1: slave 0 holds a 4-beat burst (last on beat 4); slave 1 requests from cycle 1 → grants 0,0,0,0 then 1; locked=1 from after beat 1 until after beat 4.
- Mid-burst gap: locked to slave 1, slave 1 FIFO empties for 3 cycles while slave 0 requests → grant_valid=0 and no push for 3 cycles; slave 0 is not granted until slave 1's last beat.
- Backpressure: full=1 for 5 cycles during LOCKED → push_to_fifo=0; grant_slave_number, state and rr_ptr unchanged; the burst resumes at the same beat.
- Destination filter, masters=2, i_am_master_number=1: slave 0 head dest=0, slave 1 head dest=1 → grant=1 only; with both dest=0 → grant_valid=0.
- Reset mid-burst: ARESETn=0 for 1 cycle while LOCKED on slave 1 → next cycle state=IDLE, locked=0; with slaves 0 and 1 requesting, grant=0.
